sm83_alu_seq: RTL and testbench
===============================

Name: sm83_alu_seq

Overview:
Sequencer that drives the split-nibble sm83 ALU datapath. It accepts one 8-bit ALU/shift operation per request, presents operands on the ALU bus, and generates the load, output-enable, carry-control and nibble-select strobes in order. It collects the ALU status outputs into Z/N/H/C flags and signals the register file when the result on the ALU bus is to be written. It sits between instruction decode and the ALU.

Parameters:
ALU_WIDTH, 4, core slice width; the word is 2*ALU_WIDTH bits. All concrete values below use the default.

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
start  in  1  request; sampled only while busy=0
op  in  4  0 ADD,1 ADC,2 SUB,3 SBC,4 AND,5 XOR,6 OR,7 CP,8 INC,9 DEC,10 RLC,11 RRC,12 RL,13 RR,14 SLA,15 SRL
opa, opb  in  8  operands; opb ignored for INC, DEC and shifts
c_in  in  1  current carry flag
busy  out  1  operation in progress
done  out  1  single-cycle completion pulse
result_we  out  1  ALU bus holds the result this cycle
flags  out  4  {Z,N,H,C}
alu_din  out  8  ALU bus input
load_a, load_b, load_b_zero, shift_l, shift_r, shift_in, carry_in, result_oe, shift_oe, no_carry_out, force_carry, ignore_carry, negate, op_low, op_b_high  out  1 each  ALU controls
alu_carry, alu_zero, shift_dbh, shift_dbl  in  1 each  ALU status

Behaviour:
- FSM states: IDLE, LDA, LDB, LO, HI, SH. Reset forces IDLE regardless of state; a cancelled operation produces no done and no result_we.
- Reset values: all outputs 0. flags=0000, alu_din=0.
- In IDLE, all ALU controls are 0 and alu_din=0.
- Accepting a request: start=1 in IDLE latches op, opa, opb and c_in.
  - ops 0-9: go to LDA.
  - ops 10-15: go to SH.
- start is ignored while busy=1.
- busy=1 from the cycle after acceptance through the done cycle inclusive. The next request can be accepted in the cycle after done.
- LDA: alu_din=opa, shift_oe=1, load_a=1.
- LDB: alu_din=opa, shift_oe=1.
  - INC/DEC: load_b_zero=1.
  - All other ops: alu_din=opb, load_b=1.
- LO: op_low=1, op_b_high=0. Register alu_carry at the end of the cycle as cy_lo.
- HI: op_low=0, op_b_high=1, carry_in=cy_lo, result_oe=1, done=1.
  - result_we=1 except for CP.
  - Z=alu_zero.
  - C=alu_carry, inverted for SUB/SBC/CP.
  - INC/DEC leave C unchanged.
- Carry_in and negate for the LO cycle:
  - ADD: carry_in 0.
  - ADC: carry_in = latched C.
  - SUB/CP: carry_in 1, negate.
  - SBC: carry_in = !C, negate.
  - INC: carry_in 1.
  - DEC: carry_in 0, negate.
- H flag (arith): H=cy_lo, inverted for SUB/SBC/CP/DEC.
- N flag: N=1 for SUB/SBC/CP/DEC, otherwise N=0.
- Logic ops: the R/S/V controls (no_carry_out/force_carry/ignore_carry) are held in both LO and HI.
  - AND: R0 S1 V0, carry_in 1; flags H=1, N=0, C=0.
  - XOR: R1 S0 V0, carry_in 0; flags H=0, N=0, C=0.
  - OR: R1 S0 V1, carry_in 0; flags H=0, N=0, C=0.
- SH: alu_din=opa, shift_oe=1, result_we=1, done=1, Z=alu_zero, N=0, H=0.
  - Left ops (RLC, RL, SLA): shift_l=1, C=shift_dbh.
  - Right ops (RRC, RR, SRL): shift_r=1, C=shift_dbl.
  - shift_in: RLC=opa[7], RRC=opa[0], RL/RR = latched C, SLA/SRL = 0.
- flags register update: flags update on the clock edge ending the done cycle, are visible from the next cycle, and are held until the next done.
- Latency: arithmetic/logic done is asserted 4 cycles after the accepting edge; shifts 1 cycle after.

Test Plan:
- ADD opa=3A opb=C6 -> HI: bus 00, result_we=1; flags Z1 N0 H1 C1; done 4 cycles after start.
- SUB 3E,0F -> result 2F, flags 0110. SBC 3B,2A with C=1 -> result 10, flags 0100.
- ADC E1,0F with c_in=1 -> result F1, flags 0010. DEC 01 with c_in=1 -> result 00, flags 1101 (C unchanged).
- CP 3C,40 -> result_we stays 0 throughout, flags 0101. AND 5A,3F -> result 1A, flags 0010. OR 00,00 -> flags 1000.
- SRL 01 -> result 00, flags 1001, done 1 cycle after start. RLC 85 -> 0B, flags 0001. RR 01 with c_in=1 -> 80, flags 0001.
- reset asserted during LO -> next cycle busy=0, all controls 0, no done/result_we, flags 0000. start asserted while busy=1 is ignored. A following ADD 01,01 -> result 02, flags 0000.

Source files
------------

// File: rtl/sm83_alu_seq_if.sv
// rtl/sm83_alu_seq_if.sv - request, ALU control and ALU status bundle for the sm83 ALU sequencer
interface sm83_alu_seq_if #(
  parameter int ALU_WIDTH = 4
) ();
  localparam int W = 2 * ALU_WIDTH;

  logic         start;
  logic [3:0]   op;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         c_in;
  logic         busy;
  logic         done;
  logic         result_we;
  logic [3:0]   flags;
  logic [W-1:0] alu_din;
  logic         load_a, load_b, load_b_zero, shift_l, shift_r, shift_in, carry_in;
  logic         result_oe, shift_oe, no_carry_out, force_carry, ignore_carry;
  logic         negate, op_low, op_b_high;
  logic         alu_carry, alu_zero, shift_dbh, shift_dbl;

  modport slave (
    input  start, op, opa, opb, c_in, alu_carry, alu_zero, shift_dbh, shift_dbl,
    output busy, done, result_we, flags, alu_din,
    output load_a, load_b, load_b_zero, shift_l, shift_r, shift_in, carry_in,
    output result_oe, shift_oe, no_carry_out, force_carry, ignore_carry,
    output negate, op_low, op_b_high
  );

  modport master (
    output start, op, opa, opb, c_in, alu_carry, alu_zero, shift_dbh, shift_dbl,
    input  busy, done, result_we, flags, alu_din,
    input  load_a, load_b, load_b_zero, shift_l, shift_r, shift_in, carry_in,
    input  result_oe, shift_oe, no_carry_out, force_carry, ignore_carry,
    input  negate, op_low, op_b_high
  );
endinterface

// File: rtl/sm83_alu_seq.sv
// rtl/sm83_alu_seq.sv - sequencer driving the split-nibble sm83 ALU and collecting Z/N/H/C
module sm83_alu_seq #(
  parameter int ALU_WIDTH = 4
) (
  input logic           clk,
  input logic           reset,
  sm83_alu_seq_if.slave bus
);
  localparam int W = 2 * ALU_WIDTH;

  localparam logic [3:0] OP_ADD = 4'd0, OP_ADC = 4'd1, OP_SUB = 4'd2, OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4, OP_XOR = 4'd5, OP_OR  = 4'd6, OP_CP  = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8, OP_DEC = 4'd9, OP_RLC = 4'd10, OP_RRC = 4'd11;
  localparam logic [3:0] OP_RL  = 4'd12, OP_RR = 4'd13;

  typedef enum logic [2:0] {S_IDLE, S_LDA, S_LDB, S_LO, S_HI, S_SH} state_t;

  state_t       state, state_nx;
  logic [3:0]   op_q;
  logic [W-1:0] opa_q, opb_q;
  logic         c_q, cy_lo;
  logic [3:0]   flags_q, flags_nx;

  logic is_sub, is_neg, is_incdec, is_logic, is_left;
  logic r_ctl, s_ctl, v_ctl;

  assign is_sub    = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP);
  assign is_neg    = is_sub || (op_q == OP_DEC);
  assign is_incdec = (op_q == OP_INC) || (op_q == OP_DEC);
  assign is_logic  = (op_q == OP_AND) || (op_q == OP_XOR) || (op_q == OP_OR);
  // Left shifts (RLC, RL, SLA) are the even codes of the shift group
  assign is_left   = ~op_q[0];
  assign r_ctl     = (op_q == OP_XOR) || (op_q == OP_OR);
  assign s_ctl     = (op_q == OP_AND);
  assign v_ctl     = (op_q == OP_OR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      c_q     <= 1'b0;
      cy_lo   <= 1'b0;
      flags_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && bus.start) begin
        op_q  <= bus.op;
        opa_q <= bus.opa;
        opb_q <= bus.opb;
        c_q   <= bus.c_in;
      end
      if (state == S_LO) cy_lo <= bus.alu_carry;
      if (state == S_HI || state == S_SH) flags_q <= flags_nx;
    end
  end

  always_comb begin
    state_nx         = state;
    flags_nx         = flags_q;
    bus.busy         = (state != S_IDLE);
    bus.done         = 1'b0;
    bus.result_we    = 1'b0;
    bus.flags        = flags_q;
    bus.alu_din      = '0;
    bus.load_a       = 1'b0;
    bus.load_b       = 1'b0;
    bus.load_b_zero  = 1'b0;
    bus.shift_l      = 1'b0;
    bus.shift_r      = 1'b0;
    bus.shift_in     = 1'b0;
    bus.carry_in     = 1'b0;
    bus.result_oe    = 1'b0;
    bus.shift_oe     = 1'b0;
    bus.no_carry_out = 1'b0;
    bus.force_carry  = 1'b0;
    bus.ignore_carry = 1'b0;
    bus.negate       = 1'b0;
    bus.op_low       = 1'b0;
    bus.op_b_high    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nx = (bus.op >= OP_RLC) ? S_SH : S_LDA;
      end
      S_LDA: begin
        bus.alu_din  = opa_q;
        bus.shift_oe = 1'b1;
        bus.load_a   = 1'b1;
        state_nx     = S_LDB;
      end
      S_LDB: begin
        bus.alu_din      = is_incdec ? opa_q : opb_q;
        bus.shift_oe     = 1'b1;
        bus.load_b_zero  = is_incdec;
        bus.load_b       = ~is_incdec;
        state_nx         = S_LO;
      end
      S_LO: begin
        bus.op_low       = 1'b1;
        bus.negate       = is_neg;
        bus.no_carry_out = r_ctl;
        bus.force_carry  = s_ctl;
        bus.ignore_carry = v_ctl;
        case (op_q)
          OP_ADC:                bus.carry_in = c_q;
          OP_SBC:                bus.carry_in = ~c_q;
          OP_SUB, OP_CP, OP_INC,
          OP_AND:                bus.carry_in = 1'b1;
          default:               bus.carry_in = 1'b0;
        endcase
        state_nx = S_HI;
      end
      S_HI: begin
        // negate stays up so the high nibble of B is complemented as well
        bus.op_b_high    = 1'b1;
        bus.carry_in     = cy_lo;
        bus.negate       = is_neg;
        bus.no_carry_out = r_ctl;
        bus.force_carry  = s_ctl;
        bus.ignore_carry = v_ctl;
        bus.result_oe    = 1'b1;
        bus.done         = 1'b1;
        bus.result_we    = (op_q != OP_CP);
        if (is_logic)
          flags_nx = {bus.alu_zero, 1'b0, (op_q == OP_AND), 1'b0};
        else
          flags_nx = {bus.alu_zero, is_neg, cy_lo ^ is_neg,
                      is_incdec ? c_q : (bus.alu_carry ^ is_sub)};
        state_nx = S_IDLE;
      end
      S_SH: begin
        bus.alu_din   = opa_q;
        bus.shift_oe  = 1'b1;
        bus.result_we = 1'b1;
        bus.done      = 1'b1;
        bus.shift_l   = is_left;
        bus.shift_r   = ~is_left;
        case (op_q)
          OP_RLC:       bus.shift_in = opa_q[W-1];
          OP_RRC:       bus.shift_in = opa_q[0];
          OP_RL, OP_RR: bus.shift_in = c_q;
          default:      bus.shift_in = 1'b0;
        endcase
        flags_nx = {bus.alu_zero, 2'b00, is_left ? bus.shift_dbh : bus.shift_dbl};
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_sm83_alu_seq.sv
// tb/tb_sm83_alu_seq.sv - randomized bench for sm83_alu_seq with a behavioural ALU and flag model
module tb_sm83_alu_seq;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  sm83_alu_seq_if #(.ALU_WIDTH(4)) ifc ();
  sm83_alu_seq #(.ALU_WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(ifc.slave));

  // Behavioural ALU: nibble adder with operand registers, logic unit and shifter
  logic [7:0] m_a = '0, m_b = '0, b_eff, m_logic, m_res;
  logic [3:0] m_lo = '0;
  logic [4:0] lo_sum, hi_sum;
  logic       noise = 1'b0, logic_mode;

  always_comb begin
    b_eff      = ifc.negate ? ~m_b : m_b;
    lo_sum     = {1'b0, m_a[3:0]} + {1'b0, b_eff[3:0]} + {4'b0, ifc.carry_in};
    hi_sum     = {1'b0, m_a[7:4]} + {1'b0, b_eff[7:4]} + {4'b0, ifc.carry_in};
    logic_mode = ifc.no_carry_out | ifc.force_carry | ifc.ignore_carry;
    if (ifc.force_carry)       m_logic = m_a & m_b;
    else if (ifc.ignore_carry) m_logic = m_a | m_b;
    else                       m_logic = m_a ^ m_b;
    if (ifc.shift_oe && ifc.shift_l)      m_res = {ifc.alu_din[6:0], ifc.shift_in};
    else if (ifc.shift_oe && ifc.shift_r) m_res = {ifc.shift_in, ifc.alu_din[7:1]};
    else if (logic_mode)                  m_res = m_logic;
    else                                  m_res = {hi_sum[3:0], m_lo};
  end

  assign ifc.alu_carry = ifc.op_low ? lo_sum[4] :
                         (ifc.op_b_high && !logic_mode) ? hi_sum[4] : noise;
  assign ifc.alu_zero  = (m_res == 8'h00);
  assign ifc.shift_dbh = ifc.alu_din[7];
  assign ifc.shift_dbl = ifc.alu_din[0];

  always @(posedge clk) begin
    if (ifc.load_a)      m_a <= ifc.alu_din;
    if (ifc.load_b)      m_b <= ifc.alu_din;
    if (ifc.load_b_zero) m_b <= 8'h00;
    if (ifc.op_low)      m_lo <= lo_sum[3:0];
    noise <= 1'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic c, output logic [7:0] r, output logic [3:0] f,
                                 output logic we);
    int  ai, bi, ci, s;
    logic n, h, cy;
    ai = int'(a); bi = int'(b); ci = c ? 1 : 0;
    we = 1'b1; n = 1'b0; h = 1'b0; cy = 1'b0; s = 0;
    case (op)
      4'd0:  begin s = ai + bi;      h = (ai % 16 + bi % 16) > 15;      cy = s > 255; end
      4'd1:  begin s = ai + bi + ci; h = (ai % 16 + bi % 16 + ci) > 15; cy = s > 255; end
      4'd2, 4'd7: begin
        s = ai - bi; h = (ai % 16) < (bi % 16); cy = ai < bi; n = 1'b1;
        we = (op != 4'd7);
      end
      4'd3:  begin s = ai - bi - ci; h = (ai % 16) < (bi % 16 + ci); cy = ai < bi + ci; n = 1'b1; end
      4'd4:  begin s = ai & bi; h = 1'b1; end
      4'd5:  s = ai ^ bi;
      4'd6:  s = ai | bi;
      4'd8:  begin s = ai + 1; h = (ai % 16) == 15; cy = c; end
      4'd9:  begin s = ai - 1; h = (ai % 16) == 0;  cy = c; n = 1'b1; end
      4'd10: begin s = (ai << 1) | (ai >> 7);        cy = a[7]; end
      4'd11: begin s = (ai >> 1) | ((ai & 1) << 7);  cy = a[0]; end
      4'd12: begin s = (ai << 1) | ci;               cy = a[7]; end
      4'd13: begin s = (ai >> 1) | (ci << 7);        cy = a[0]; end
      4'd14: begin s = ai << 1;                      cy = a[7]; end
      default: begin s = ai >> 1;                    cy = a[0]; end
    endcase
    r = 8'(s);
    f = {(r == 8'h00), n, h, cy};
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [7:0] er;
    logic [3:0] ef;
    logic       ewe;
    int         lat, cyc;
    bit         seen;
    ref_op(op, a, b, c, er, ef, ewe);
    lat = (op >= 4'd10) ? 1 : 4;
    @(negedge clk);
    check("idle_busy", ifc.busy, 0);
    ifc.start = 1'b1; ifc.op = op; ifc.opa = a; ifc.opb = b; ifc.c_in = c;
    seen = 0; cyc = 0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      check("busy", ifc.busy, 1);
      if (ifc.done) begin
        seen = 1;
        ifc.start = 1'b0;
        check("latency", cyc, lat);
        check("result", m_res, er);
        check("result_we", ifc.result_we, ewe);
      end else begin
        check("early_we", ifc.result_we, 0);
        ifc.start = 1'($urandom); ifc.op = 4'($urandom);
        ifc.opa = 8'($urandom); ifc.opb = 8'($urandom); ifc.c_in = 1'($urandom);
      end
    end
    ifc.start = 1'b0;
    check("done_seen", seen, 1);
    @(negedge clk);
    check("flags", ifc.flags, ef);
    check("busy_after", ifc.busy, 0);
    check("done_after", ifc.done, 0);
  endtask

  function automatic logic [15:0] ctl_vec();
    return {ifc.load_a, ifc.load_b, ifc.load_b_zero, ifc.shift_l, ifc.shift_r, ifc.shift_in,
            ifc.carry_in, ifc.result_oe, ifc.shift_oe, ifc.no_carry_out, ifc.force_carry,
            ifc.ignore_carry, ifc.negate, ifc.op_low, ifc.op_b_high, ifc.result_we};
  endfunction

  initial begin
    int dcount;
    reset = 1'b1;
    ifc.start = 1'b0; ifc.op = '0; ifc.opa = '0; ifc.opb = '0; ifc.c_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", ifc.busy, 0);
    check("rst_done", ifc.done, 0);
    check("rst_flags", ifc.flags, 0);
    check("rst_din", ifc.alu_din, 0);
    check("rst_ctl", ctl_vec(), 0);
    reset = 1'b0;

    run_op(4'd0,  8'h3A, 8'hC6, 1'b0);
    run_op(4'd2,  8'h3E, 8'h0F, 1'b0);
    run_op(4'd3,  8'h3B, 8'h2A, 1'b1);
    run_op(4'd1,  8'hE1, 8'h0F, 1'b1);
    run_op(4'd9,  8'h01, 8'h55, 1'b1);
    run_op(4'd7,  8'h3C, 8'h40, 1'b0);
    run_op(4'd4,  8'h5A, 8'h3F, 1'b0);
    run_op(4'd6,  8'h00, 8'h00, 1'b1);
    run_op(4'd15, 8'h01, 8'h00, 1'b0);
    run_op(4'd10, 8'h85, 8'h00, 1'b0);
    run_op(4'd13, 8'h01, 8'h00, 1'b1);

    // Abort an ADD while the low nibble is being computed
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = 4'd0; ifc.opa = 8'h12; ifc.opb = 8'h34; ifc.c_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      ifc.start = 1'b0;
    end
    check("lo_reached", ifc.op_low, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", ifc.busy, 0);
    check("abort_done", ifc.done, 0);
    check("abort_flags", ifc.flags, 0);
    check("abort_din", ifc.alu_din, 0);
    check("abort_ctl", ctl_vec(), 0);
    dcount = 0;
    repeat (5) begin
      @(negedge clk);
      if (ifc.done || ifc.result_we) dcount++;
    end
    check("abort_quiet", dcount, 0);
    run_op(4'd0, 8'h01, 8'h01, 1'b0);

    for (int i = 0; i < 150; i++)
      run_op(4'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
